// File: rtl/register_file.sv
// 4 x 16-bit register file: one synchronous write port, two registered read ports
// with read enable and write-first bypass when a read hits the entry being written.
module register_file #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write_en,
  input  logic                  read_en,
  input  logic [ADDR_WIDTH-1:0] write_adr,
  input  logic [ADDR_WIDTH-1:0] read_adr1,
  input  logic [ADDR_WIDTH-1:0] read_adr2,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] reg_file [0:DEPTH-1];

  logic                  hit1;
  logic                  hit2;
  logic [DATA_WIDTH-1:0] next_data1;
  logic [DATA_WIDTH-1:0] next_data2;

  // A read of the entry being written this edge returns the new data, never the old contents.
  always_comb begin
    hit1       = write_en && (read_adr1 == write_adr);
    hit2       = write_en && (read_adr2 == write_adr);
    next_data1 = hit1 ? write_data : reg_file[read_adr1];
    next_data2 = hit2 ? write_data : reg_file[read_adr2];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        reg_file[i] <= '0;
      end
      read_data1 <= '0;
      read_data2 <= '0;
    end else begin
      if (write_en) begin
        reg_file[write_adr] <= write_data;
      end
      if (read_en) begin
        read_data1 <= next_data1;
        read_data2 <= next_data2;
      end
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios plus randomized traffic
// compared against an array-based reference model.
module tb_register_file;

  logic        clk;
  logic        reset;
  logic        write_en;
  logic        read_en;
  logic [1:0]  write_adr;
  logic [1:0]  read_adr1;
  logic [1:0]  read_adr2;
  logic [15:0] write_data;
  logic [15:0] read_data1;
  logic [15:0] read_data2;

  int checks = 0;
  int errors = 0;

  logic [15:0] model_mem [0:3];
  logic [15:0] model_rd1;
  logic [15:0] model_rd2;

  register_file #(.DATA_WIDTH(16), .ADDR_WIDTH(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .write_en   (write_en),
    .read_en    (read_en),
    .write_adr  (write_adr),
    .read_adr1  (read_adr1),
    .read_adr2  (read_adr2),
    .write_data (write_data),
    .read_data1 (read_data1),
    .read_data2 (read_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge with reset high, updating the reference model from the current inputs.
  task automatic step();
    logic [15:0] n1;
    logic [15:0] n2;
    n1 = model_rd1;
    n2 = model_rd2;
    if (read_en) begin
      n1 = (write_en && read_adr1 == write_adr) ? write_data : model_mem[read_adr1];
      n2 = (write_en && read_adr2 == write_adr) ? write_data : model_mem[read_adr2];
    end
    if (write_en) model_mem[write_adr] = write_data;
    model_rd1 = n1;
    model_rd2 = n2;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [1:0] wa, input logic [15:0] wd,
                       input logic re, input logic [1:0] ra1, input logic [1:0] ra2);
    write_en   = we;
    write_adr  = wa;
    write_data = wd;
    read_en    = re;
    read_adr1  = ra1;
    read_adr2  = ra2;
  endtask

  task automatic preload();
    drive(1'b1, 2'd0, 16'hCCCC, 1'b0, 2'd0, 2'd0); step();
    drive(1'b1, 2'd1, 16'hAAAA, 1'b0, 2'd0, 2'd0); step();
    drive(1'b1, 2'd2, 16'hF0F0, 1'b0, 2'd0, 2'd0); step();
    drive(1'b1, 2'd3, 16'h8E38, 1'b0, 2'd0, 2'd0); step();
    drive(1'b0, 2'd0, 16'h0000, 1'b0, 2'd0, 2'd0);
  endtask

  task automatic test_reset();
    logic [15:0] entry;
    drive(1'b0, 2'd0, 16'h0000, 1'b0, 2'd0, 2'd0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) model_mem[i] = 16'h0000;
    model_rd1 = 16'h0000;
    model_rd2 = 16'h0000;
    preload();
    drive(1'b0, 2'd0, 16'h0000, 1'b1, 2'd2, 2'd3); step();
    drive(1'b0, 2'd0, 16'h0000, 1'b0, 2'd0, 2'd0);
    // Assert reset mid-cycle; everything must clear without waiting for an edge.
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (read_data1 !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_rd1 got %h expected 0000", read_data1);
    end
    checks++;
    if (read_data2 !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_rd2 got %h expected 0000", read_data2);
    end
    for (int i = 0; i < 4; i++) begin
      entry = dut.reg_file[i];
      checks++;
      if (entry !== 16'h0000) begin
        errors++;
        $display("[TB] FAIL reset_entry%0d got %h expected 0000", i, entry);
      end
    end
    // A write on an edge while reset is low is discarded.
    drive(1'b1, 2'd0, 16'h5555, 1'b1, 2'd0, 2'd0);
    @(posedge clk);
    #1;
    entry = dut.reg_file[0];
    checks++;
    if (entry !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_write_ignored got %h expected 0000", entry);
    end
    checks++;
    if (read_data1 !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_read_ignored got %h expected 0000", read_data1);
    end
    drive(1'b0, 2'd0, 16'h0000, 1'b0, 2'd0, 2'd0);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) model_mem[i] = 16'h0000;
    model_rd1 = 16'h0000;
    model_rd2 = 16'h0000;
  endtask

  task automatic test_basic_read();
    preload();
    drive(1'b0, 2'd0, 16'h0000, 1'b1, 2'd0, 2'd1); step();
    checks++;
    if (read_data1 !== 16'hCCCC || read_data2 !== 16'hAAAA) begin
      errors++;
      $display("[TB] FAIL basic_read_01 got %h/%h expected CCCC/AAAA", read_data1, read_data2);
    end
    drive(1'b0, 2'd0, 16'h0000, 1'b1, 2'd2, 2'd3); step();
    checks++;
    if (read_data1 !== 16'hF0F0 || read_data2 !== 16'h8E38) begin
      errors++;
      $display("[TB] FAIL basic_read_23 got %h/%h expected F0F0/8E38", read_data1, read_data2);
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 2'd0, 16'h0000, 1'b0, 2'(i), 2'(i + 1)); step();
      checks++;
      if (read_data1 !== 16'hF0F0 || read_data2 !== 16'h8E38) begin
        errors++;
        $display("[TB] FAIL hold_%0d got %h/%h expected F0F0/8E38", i, read_data1, read_data2);
      end
    end
  endtask

  task automatic test_write_read();
    drive(1'b1, 2'd2, 16'hFFFF, 1'b0, 2'd0, 2'd0); step();
    drive(1'b0, 2'd0, 16'h0000, 1'b1, 2'd2, 2'd3); step();
    checks++;
    if (read_data1 !== 16'hFFFF || read_data2 !== 16'h8E38) begin
      errors++;
      $display("[TB] FAIL write_read got %h/%h expected FFFF/8E38", read_data1, read_data2);
    end
    drive(1'b0, 2'd0, 16'h0000, 1'b1, 2'd0, 2'd1); step();
    checks++;
    if (read_data1 !== 16'hCCCC || read_data2 !== 16'hAAAA) begin
      errors++;
      $display("[TB] FAIL write_read_others got %h/%h expected CCCC/AAAA", read_data1, read_data2);
    end
  endtask

  task automatic test_bypass();
    drive(1'b1, 2'd1, 16'h1234, 1'b1, 2'd1, 2'd1); step();
    checks++;
    if (read_data1 !== 16'h1234 || read_data2 !== 16'h1234) begin
      errors++;
      $display("[TB] FAIL bypass_both got %h/%h expected 1234/1234", read_data1, read_data2);
    end
    drive(1'b1, 2'd0, 16'h0BAD, 1'b1, 2'd1, 2'd0); step();
    checks++;
    if (read_data1 !== 16'h1234 || read_data2 !== 16'h0BAD) begin
      errors++;
      $display("[TB] FAIL bypass_port2 got %h/%h expected 1234/0BAD", read_data1, read_data2);
    end
  endtask

  task automatic test_write_disabled();
    drive(1'b0, 2'd3, 16'h0000, 1'b0, 2'd0, 2'd0); step();
    drive(1'b0, 2'd3, 16'h0000, 1'b1, 2'd3, 2'd3); step();
    checks++;
    if (read_data1 !== 16'h8E38 || read_data2 !== 16'h8E38) begin
      errors++;
      $display("[TB] FAIL write_disabled got %h/%h expected 8E38/8E38", read_data1, read_data2);
    end
  endtask

  task automatic test_random();
    logic [15:0] entry;
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom), 2'($urandom), 16'($urandom), 1'($urandom_range(0, 3) != 0),
            2'($urandom), 2'($urandom));
      step();
      checks++;
      if (read_data1 !== model_rd1 || read_data2 !== model_rd2) begin
        errors++;
        $display("[TB] FAIL random_%0d got %h/%h expected %h/%h",
                 n, read_data1, read_data2, model_rd1, model_rd2);
      end
    end
    for (int i = 0; i < 4; i++) begin
      entry = dut.reg_file[i];
      checks++;
      if (entry !== model_mem[i]) begin
        errors++;
        $display("[TB] FAIL random_entry%0d got %h expected %h", i, entry, model_mem[i]);
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 2'd0, 16'h0000, 1'b0, 2'd0, 2'd0);
    test_reset();
    test_basic_read();
    test_hold();
    test_write_read();
    test_bypass();
    test_write_disabled();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- Small multi-port register file for the 16-bit CPU datapath: 4 entries x 16 bits.
- One synchronous write port and two read ports.
- Read ports are registered and gated by a read enable. The operand fetch stage reads two source registers per cycle; writeback writes one.

Parameters:
- DATA_WIDTH, 16, width of each register and of the data ports.
- ADDR_WIDTH, 2, address width; depth = 2**ADDR_WIDTH (4 entries).

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset (reset = 0 resets).
- write_en  input  1  write enable for the write port.
- read_en  input  1  read enable for both read ports.
- write_adr  input  ADDR_WIDTH  write address.
- read_adr1  input  ADDR_WIDTH  read port 1 address.
- read_adr2  input  ADDR_WIDTH  read port 2 address.
- write_data  input  DATA_WIDTH  data to write.
- read_data1  output  DATA_WIDTH  registered read port 1 data.
- read_data2  output  DATA_WIDTH  registered read port 2 data.

Behaviour:
- Storage is an array named reg_file[0:2**ADDR_WIDTH-1] of DATA_WIDTH bits. Benches may preload it hierarchically.

Reset:
- reset low, asynchronously and immediately: all reg_file entries = 0, read_data1 = 0, read_data2 = 0.
- Held while reset is low; writes and reads are ignored.
- Release is sampled at the next rising clk edge.

Write:
- On rising clk with reset high and write_en = 1: reg_file[write_adr] <= write_data.
- write_en = 0: no entry changes.

Read:
- On rising clk with reset high and read_en = 1: read_data1 <= entry at read_adr1 and read_data2 <= entry at read_adr2.
- Latency is 1 cycle from the address/enable sample edge to valid output.
- read_en = 0: both outputs hold their previous values.

Read-during-write:
- Applies when the same edge has write_en = 1, read_en = 1 and read_adrN == write_adr.
- read_dataN gets write_data (write-first bypass); it never returns the old contents.
- Bypass applies independently to each port; both ports may bypass together.

Other rules:
- Both read ports may address the same entry; both return the same value.
- Addresses are exactly ADDR_WIDTH bits, so there is no out-of-range case.
- If reset asserts mid-cycle, state clears immediately. A write on the edge coinciding with reset low is discarded.
- X or Z on addresses when the corresponding enable is 0 has no effect on state.

Test Plan:
- Reset: preload reg_file = {CCCC, AAAA, F0F0, 8E38}, drive reset = 0 -> all entries and both outputs read 0000 immediately, without a clock edge.
- Basic read: preload as above, reset = 1, read_en = 1, read_adr1 = 0, read_adr2 = 1 -> after one rising edge read_data1 = CCCC, read_data2 = AAAA. Then read_adr1 = 2, read_adr2 = 3 -> next edge F0F0 / 8E38.
- Hold: read_en = 0, change addresses -> outputs keep previous values across 3 edges.
- Write then read: write_en = 1, write_adr = 2, write_data = FFFF for one edge, then write_en = 0, read_en = 1, read_adr1 = 2 -> read_data1 = FFFF. Entries 0, 1 and 3 are unchanged.
- Bypass: write_en = 1, read_en = 1, write_adr = 1, write_data = 1234, read_adr1 = 1, read_adr2 = 1 -> after the same edge both outputs = 1234.
- Write disabled: write_en = 0, write_adr = 3, write_data = 0000 -> entry 3 still reads 8E38.
